// File: rtl/gf_2to128_digit_serial_multiplier.sv
// ----------------------------------------------------------------------------
// gf_2to128_digit_serial_multiplier
//   Iterative GF(2^128) multiplier for the GHASH datapath. It computes
//   o_data = i_data_x * i_data_h mod (x^128 + x^7 + x^2 + x + 1) in GCM bit
//   order, where bit NB_DATA-1 holds x^0 and bit 0 holds x^127.
//   X is consumed N_SUBPROD bits per cycle in Horner order, starting with the
//   highest-degree digit.
//
// Ports
//   i_clock    : clock; all state updates on the rising edge
//   i_reset    : synchronous, active-high reset
//   i_valid    : operand pair valid
//   o_ready    : block can accept operands (IDLE only)
//   i_data_x   : multiplicand X (GHASH input block)
//   i_data_h   : multiplier H (hash subkey)
//   o_valid    : result valid; held until consumed
//   i_ready    : downstream accepts the result
//   o_data     : product X*H (zero whenever o_valid is low)
//   dbg_state  : current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
//
// Handshake: a transfer occurs on a rising edge where valid and ready are both
// high. Operands are sampled only on the accepting edge. The result and
// o_valid stay put until i_ready is seen; o_ready is low for the whole
// operation, so operands offered while busy are dropped, not queued.
// ----------------------------------------------------------------------------

// Reduction of the digit shifted out below bit 0 of the accumulator.
// Input bit i lands at degree 128 + (N_SUBPROD-1-i) after the shift; its
// reduced form is R * x^(N_SUBPROD-1-i), with R = x^7+x^2+x+1. The per-bit
// terms are elaboration-time constants built with the same multiply-by-x step
// as the datapath, so any overflow past x^127 is folded back again.
module gf_2to128_multiplier_booth1_subrem #(
  parameter int NB_DATA   = 128,
  parameter int N_SUBPROD = 8
) (
  input  logic [N_SUBPROD-1:0] i_data,
  output logic [NB_DATA-1:0]   o_data
);

  localparam logic [NB_DATA-1:0] R_POLY = {8'he1, {(NB_DATA-8){1'b0}}};

  function automatic logic [NB_DATA-1:0] mul_x(input logic [NB_DATA-1:0] v);
    return v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
  endfunction

  function automatic logic [NB_DATA-1:0] red_term(input int k);
    logic [NB_DATA-1:0] t;
    t = R_POLY;
    for (int s = 0; s < k; s++) t = mul_x(t);
    return t;
  endfunction

  logic [NB_DATA-1:0] terms [N_SUBPROD];

  for (genvar i = 0; i < N_SUBPROD; i++) begin : g_term
    localparam logic [NB_DATA-1:0] TERM = red_term(N_SUBPROD - 1 - i);
    assign terms[i] = i_data[i] ? TERM : '0;
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < N_SUBPROD; i++) o_data = o_data ^ terms[i];
  end

endmodule

module gf_2to128_digit_serial_multiplier #(
  parameter int NB_DATA   = 128,
  parameter int N_SUBPROD = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic [NB_DATA-1:0] i_data_h,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic [1:0]         dbg_state
);

  localparam int K  = NB_DATA / N_SUBPROD;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [NB_DATA-1:0] R_POLY = {8'he1, {(NB_DATA-8){1'b0}}};

  if ((NB_DATA != 128) || ((NB_DATA % N_SUBPROD) != 0) || (N_SUBPROD < 7))
  begin : g_bad_config
    $error("gf_2to128_digit_serial_multiplier: unsupported NB_DATA/N_SUBPROD");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [NB_DATA-1:0] x_q, h_q, z_q;
  logic [NB_DATA-1:0] hx_q [N_SUBPROD];
  logic [NB_DATA-1:0] hx_d [N_SUBPROD];
  logic [CW-1:0]      cnt_q;

  logic [N_SUBPROD-1:0] digit;
  logic [NB_DATA-1:0]   partial;
  logic [NB_DATA-1:0]   overflow_red;
  logic [NB_DATA-1:0]   z_nx;

  function automatic logic [NB_DATA-1:0] mul_x(input logic [NB_DATA-1:0] v);
    return v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
  endfunction

  // H * x^m for every bit position of a digit; registered once in LOAD.
  always_comb begin
    logic [NB_DATA-1:0] v;
    v = h_q;
    for (int m = 0; m < N_SUBPROD; m++) begin
      hx_d[m] = v;
      v       = mul_x(v);
    end
  end

  // Digit bit j carries degree (N_SUBPROD-1-j) relative to the digit's lowest
  // degree, so it selects H * x^(N_SUBPROD-1-j).
  assign digit = x_q[int'(cnt_q)*N_SUBPROD +: N_SUBPROD];

  always_comb begin
    partial = '0;
    for (int j = 0; j < N_SUBPROD; j++) begin
      if (digit[j]) partial = partial ^ hx_q[N_SUBPROD-1-j];
    end
  end

  gf_2to128_multiplier_booth1_subrem #(
    .NB_DATA  (NB_DATA),
    .N_SUBPROD(N_SUBPROD)
  ) u_subrem (
    .i_data(z_q[N_SUBPROD-1:0]),
    .o_data(overflow_red)
  );

  // Horner step: Z * x^N (zero-filled shift plus folded overflow) + digit*H.
  assign z_nx = (z_q >> N_SUBPROD) ^ overflow_red ^ partial;

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (i_valid) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_RUN;
      ST_RUN:  if (cnt_q == CW'(K-1)) state_nx = ST_DONE;
      ST_DONE: if (i_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      x_q   <= '0;
      h_q   <= '0;
      z_q   <= '0;
      cnt_q <= '0;
      for (int m = 0; m < N_SUBPROD; m++) hx_q[m] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            x_q   <= i_data_x;
            h_q   <= i_data_h;
            z_q   <= '0;
            cnt_q <= '0;
          end
        end
        ST_LOAD: begin
          for (int m = 0; m < N_SUBPROD; m++) hx_q[m] <= hx_d[m];
        end
        ST_RUN: begin
          z_q   <= z_nx;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ready   = (state == ST_IDLE);
  assign o_valid   = (state == ST_DONE);
  assign o_data    = (state == ST_DONE) ? z_q : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_gf_2to128_digit_serial_multiplier.sv
// ----------------------------------------------------------------------------
// tb_gf_2to128_digit_serial_multiplier
//   Directed bench for the digit-serial GF(2^128) multiplier. Expected
//   products are hand-derived constants queued in exp_q and popped when the
//   DUT presents a result. All DUT outputs are sampled on the falling edge;
//   inputs are driven right after the falling edge.
// ----------------------------------------------------------------------------
module tb_gf_2to128_digit_serial_multiplier;

  localparam int W = 128;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst;
  always #5 clk = ~clk;

  logic         i_valid, i_ready;
  logic [W-1:0] i_data_x, i_data_h;
  logic         o_ready, o_valid;
  logic [W-1:0] o_data;
  logic [1:0]   dbg_state;

  gf_2to128_digit_serial_multiplier dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data_x (i_data_x),
    .i_data_h (i_data_h),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [W-1:0] GCM_X   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [W-1:0] GCM_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [W-1:0] GCM_P   = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [W-1:0] ONE     = 128'h80000000_00000000_00000000_00000000;
  localparam logic [W-1:0] X_1     = 128'h40000000_00000000_00000000_00000000;
  localparam logic [W-1:0] X_127   = 128'h00000000_00000000_00000000_00000001;
  localparam logic [W-1:0] X_128   = 128'he1000000_00000000_00000000_00000000;
  // x^254 = x^127 + x^126 + x^12 + x^6 + x^5 + x^2 + x + 1
  localparam logic [W-1:0] X_254   = 128'he6080000_00000000_00000000_00000003;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the falling edge of the cycle after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] h);
    int w;
    w = 0;
    while (!o_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("ready_seen", W'(o_ready), W'(1));
    i_valid  = 1'b1;
    i_data_x = x;
    i_data_h = h;
    @(negedge clk);
    i_valid  = 1'b0;
    i_data_x = rand128();
    i_data_h = rand128();
  endtask

  // Latency is counted in cycles after the accepting cycle; send() leaves us
  // in the first of those cycles.
  task automatic wait_valid(input bit check_lat);
    int lat;
    lat = 1;
    while (!o_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("valid_seen", W'(o_valid), W'(1));
    if (check_lat) check("latency", W'(lat), W'(18));
  endtask

  task automatic pop_and_check(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check(tag, o_data, e);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x,
                        input logic [W-1:0] h, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    send(x, h);
    wait_valid(1'b1);
    pop_and_check(tag);
    @(negedge clk);
    check({tag, "_valid_drop"}, W'(o_valid), W'(0));
    check({tag, "_ready_back"}, W'(o_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] r;
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_data_x = '0;
    i_data_h = '0;
    do_reset();

    // Reset state
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_data",  o_data, '0);
    check("rst_state", W'(dbg_state), W'(0));

    // Zero operands
    run_op("x_zero", '0, rand128(), '0);
    run_op("h_zero", rand128(), '0, '0);

    // Identity on either side
    r = rand128();
    run_op("h_one", r, ONE, r);
    r = rand128();
    run_op("x_one", ONE, r, r);

    // Reduction of x^128 and a two-level reduction of x^254
    run_op("x127_x1", X_127, X_1, X_128);
    run_op("x1_x127", X_1, X_127, X_128);
    run_op("x127_sq", X_127, X_127, X_254);

    // GCM test case 2, both operand orders
    run_op("gcm_tc2", GCM_X, GCM_H, GCM_P);
    run_op("gcm_tc2_swap", GCM_H, GCM_X, GCM_P);

    // Back-pressure in DONE: result held, no second accept
    i_ready = 1'b0;
    exp_q.push_back(GCM_P);
    send(GCM_X, GCM_H);
    wait_valid(1'b1);
    for (int c = 0; c < 5; c++) begin
      check("hold_data",  o_data, GCM_P);
      check("hold_ready", W'(o_ready), W'(0));
      check("hold_valid", W'(o_valid), W'(1));
      i_valid  = ~i_valid;
      i_data_x = rand128();
      i_data_h = rand128();
      @(negedge clk);
    end
    pop_and_check("hold_final");
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    check("release_ready", W'(o_ready), W'(1));
    check("release_valid", W'(o_valid), W'(0));
    check("release_state", W'(dbg_state), W'(0));
    r = rand128();
    run_op("after_hold", r, ONE, r);

    // Reset in the middle of RUN (digit counter at 7)
    send(GCM_X, GCM_H);
    repeat (8) @(negedge clk);
    check("mid_run_state", W'(dbg_state), W'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", W'(dbg_state), W'(0));
    check("abort_valid", W'(o_valid), W'(0));
    check("abort_ready", W'(o_ready), W'(1));
    check("abort_data",  o_data, '0);
    run_op("after_abort", GCM_X, GCM_H, GCM_P);
    run_op("after_abort2", X_127, X_127, X_254);

    check("queue_empty", W'(exp_q.size()), W'(0));

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
